// File: rtl/color_stabilizer.sv
// color_stabilizer: averages the 48-bit colour sensor reading per window, classifies it and debounces
// the result into a clean colour plus strobes. Define COLOR_STAB_STATS_EN to add the change_count output.
module color_stabilizer #(
   parameter int         SAMPLE_PERIOD = 1000,
   parameter int         LOG_N         = 2,
   parameter int         STABLE_COUNT  = 3,
   parameter logic [7:0] DARK_THRESH   = 8'd16,
   parameter logic [7:0] WHITE_MIN     = 8'd160
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [47:0] value,
   output logic [7:0]  avg_red,
   output logic [7:0]  avg_green,
   output logic [7:0]  avg_blue,
   output logic [2:0]  raw_color,
   output logic [2:0]  color,
   output logic        color_valid,
`ifdef COLOR_STAB_STATS_EN
   output logic [15:0] change_count,
`endif
   output logic        color_changed
);
   localparam int AW = 16 + LOG_N;
   localparam int PW = $clog2(SAMPLE_PERIOD);
   localparam int NW = LOG_N + 1;
   localparam int SW = $clog2(STABLE_COUNT + 1);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCUM, S_CLASSIFY, S_DEBOUNCE} state_t;
   state_t r_state, w_next;

   logic [PW-1:0] r_per;
   logic [NW-1:0] r_num;
   logic [SW-1:0] r_stab, w_stab;
   logic [AW-1:0] r_acc_r, r_acc_g, r_acc_b;
   logic [2:0]    r_prev, w_class;
   logic [7:0]    w_r, w_g, w_b, w_max, w_min;
   logic          w_rdom, w_same, w_pub, w_chg;

   // the high byte of the accumulator is the truncated average's high byte
   assign w_r    = r_acc_r[AW-1 -: 8];
   assign w_g    = r_acc_g[AW-1 -: 8];
   assign w_b    = r_acc_b[AW-1 -: 8];
   assign w_rdom = w_r >= w_g && w_r >= w_b;
   assign w_max  = w_rdom ? w_r : (w_g >= w_b ? w_g : w_b);
   assign w_min  = (w_r <= w_g && w_r <= w_b) ? w_r : (w_g <= w_b ? w_g : w_b);
   assign w_class = (w_max < DARK_THRESH) ? 3'd0 :
                    (w_min > WHITE_MIN) ? 3'd1 :
                    w_rdom ? (({w_g, 2'b00} >= 10'(w_r) * 10'd3) ? 3'd2 :
                              ({w_g, 2'b00} >= {2'b00, w_r}) ? 3'd4 : 3'd3) :
                    (w_g >= w_b) ? 3'd5 : 3'd6;

   // a zero stability count marks the previous class as invalid
   assign w_same = (r_stab != '0) && (raw_color == r_prev);
   assign w_stab = !w_same ? SW'(1) : (r_stab == SW'(STABLE_COUNT)) ? r_stab : r_stab + 1'b1;
   assign w_pub  = (r_state == S_DEBOUNCE) && enable && (w_stab == SW'(STABLE_COUNT)) &&
                   !(w_same && r_stab == SW'(STABLE_COUNT));
   assign w_chg  = w_pub && (raw_color != color);

   always_ff @(posedge clock)
      r_state <= (reset || !enable) ? S_IDLE : w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     w_next = S_WAIT;
         S_WAIT:     w_next = (r_per == PW'(SAMPLE_PERIOD - 2)) ? S_ACCUM : S_WAIT;
         S_ACCUM:    w_next = (r_num == NW'(2**LOG_N - 1)) ? S_CLASSIFY : S_WAIT;
         S_CLASSIFY: w_next = S_DEBOUNCE;
         S_DEBOUNCE: w_next = S_WAIT;
         default:    w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_per         <= '0;
         r_num         <= '0;
         r_stab        <= '0;
         r_prev        <= '0;
         r_acc_r       <= '0;
         r_acc_g       <= '0;
         r_acc_b       <= '0;
         avg_red       <= '0;
         avg_green     <= '0;
         avg_blue      <= '0;
         raw_color     <= '0;
         color         <= '0;
         color_valid   <= 1'b0;
         color_changed <= 1'b0;
      end else begin
         color_valid   <= w_pub;
         color_changed <= w_chg;
         if (!enable) begin
            r_per   <= '0;
            r_num   <= '0;
            r_stab  <= '0;
            r_acc_r <= '0;
            r_acc_g <= '0;
            r_acc_b <= '0;
         end else begin
            r_per <= (r_state == S_WAIT) ? r_per + 1'b1 : '0;
            if (r_state == S_ACCUM) begin
               r_acc_r <= r_acc_r + AW'(value[31:16]);
               r_acc_g <= r_acc_g + AW'(value[15:0]);
               r_acc_b <= r_acc_b + AW'(value[47:32]);
               r_num   <= r_num + 1'b1;
            end
            if (r_state == S_CLASSIFY) begin
               avg_red   <= w_r;
               avg_green <= w_g;
               avg_blue  <= w_b;
               raw_color <= w_class;
               r_acc_r   <= '0;
               r_acc_g   <= '0;
               r_acc_b   <= '0;
               r_num     <= '0;
            end
            if (r_state == S_DEBOUNCE) begin
               r_stab <= w_stab;
               r_prev <= raw_color;
            end
            if (w_pub)
               color <= raw_color;
         end
      end
   end

`ifdef COLOR_STAB_STATS_EN
   always_ff @(posedge clock)
      if (reset)
         change_count <= '0;
      else if (w_chg && change_count != 16'hFFFF)
         change_count <= change_count + 1'b1;
`endif
endmodule

// File: tb/tb_color_stabilizer.sv
// tb_color_stabilizer: directed and randomized checks of color_stabilizer against a window-level
// reference model (fast parameters: 4-clock sample period, 4 samples per window, 3 stable windows).
module tb_color_stabilizer;
   localparam int SP = 4;
   localparam int LN = 2;
   localparam int NS = 4;
   localparam int SC = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic [47:0] value = '1;
   logic [7:0]  avg_red, avg_green, avg_blue;
   logic [2:0]  raw_color, color;
   logic        color_valid, color_changed;

   color_stabilizer #(.SAMPLE_PERIOD(SP), .LOG_N(LN), .STABLE_COUNT(SC)) dut (
      .clock(clock), .reset(reset), .enable(enable), .value(value),
      .avg_red(avg_red), .avg_green(avg_green), .avg_blue(avg_blue),
      .raw_color(raw_color), .color(color), .color_valid(color_valid),
      .color_changed(color_changed)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   bit chk_on = 0;
   int dut_pulses = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int classify(input int r, input int g, input int b);
      int mx, mn;
      mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
      mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
      if (mx < 16) return 0;
      if (mn > 160) return 1;
      if (r >= g && r >= b) return (4 * g >= 3 * r) ? 2 : (4 * g >= r) ? 4 : 3;
      return (g >= b) ? 5 : 6;
   endfunction

   // window-level reference: a window spans NS*SP sample clocks plus classify and debounce clocks
   bit m_idle = 1;
   int m_p = 0, m_ns = 0, m_samples = 0, m_nwin = 0;
   int m_sr = 0, m_sg = 0, m_sb = 0;
   int m_ar = 0, m_ag = 0, m_ab = 0, m_raw = 0, m_color = 0;
   int m_valid = 0, m_chg = 0, m_run = 0, m_last = 0;

   always @(posedge clock) begin
      if (chk_on && color_valid) dut_pulses++;
      if (reset) begin
         m_idle = 1; m_p = 0; m_ns = 0; m_sr = 0; m_sg = 0; m_sb = 0;
         m_ar = 0; m_ag = 0; m_ab = 0; m_raw = 0; m_color = 0;
         m_valid = 0; m_chg = 0; m_run = 0; m_last = 0;
      end else begin
         m_valid = 0;
         m_chg = 0;
         if (!enable) begin
            m_idle = 1; m_ns = 0; m_run = 0; m_sr = 0; m_sg = 0; m_sb = 0;
         end else if (m_idle) begin
            m_idle = 0;
            m_p = 0;
         end else begin
            if (m_p < NS * SP) begin
               if (m_p % SP == SP - 1) begin
                  m_sr += int'(value[31:16]);
                  m_sg += int'(value[15:0]);
                  m_sb += int'(value[47:32]);
                  m_ns++;
                  m_samples++;
               end
            end else if (m_p == NS * SP) begin
               m_ar = (m_sr / NS) / 256;
               m_ag = (m_sg / NS) / 256;
               m_ab = (m_sb / NS) / 256;
               m_raw = classify(m_ar, m_ag, m_ab);
               m_sr = 0; m_sg = 0; m_sb = 0; m_ns = 0;
            end else begin
               m_run = (m_run > 0 && m_raw == m_last) ? m_run + 1 : 1;
               m_last = m_raw;
               if (m_run == SC) begin
                  m_chg = (m_raw != m_color) ? 1 : 0;
                  m_color = m_raw;
                  m_valid = 1;
               end
               m_nwin++;
            end
            m_p = (m_p == NS * SP + 1) ? 0 : m_p + 1;
         end
      end
   end

   always @(negedge clock)
      if (chk_on) begin
         check("avg_red", avg_red, m_ar);
         check("avg_green", avg_green, m_ag);
         check("avg_blue", avg_blue, m_ab);
         check("raw_color", raw_color, m_raw);
         check("color", color, m_color);
         check("color_valid", color_valid, m_valid);
         check("color_changed", color_changed, m_chg);
      end

   task automatic wait_win(input int k);
      int t0 = m_nwin;
      int c = 0;
      while (m_nwin < t0 + k && c < k * 40 + 40) begin @(negedge clock); c++; end
      check("win_bound", m_nwin >= t0 + k, 1);
   endtask

   task automatic wait_samp();
      int s0 = m_samples;
      int c = 0;
      while (m_samples == s0 && c < 40) begin @(negedge clock); c++; end
      check("samp_bound", m_samples > s0, 1);
   endtask

   logic [7:0]  bnd_g [4] = '{8'h6C, 8'h6B, 8'h24, 8'h23};
   int          bnd_c [4] = '{2, 4, 4, 3};
   logic [15:0] avg_r [4] = '{16'h0F00, 16'h0F00, 16'h1100, 16'h1100};
   logic [47:0] tbl   [6] = '{48'h2000_9000_1000, 48'hC000_C000_C000, 48'h8000_1000_1000,
                              48'h1000_1000_8000, 48'h0000_9000_6C00, 48'h0};
   localparam logic [47:0] RED   = 48'h2000_9000_1000;
   localparam logic [47:0] WHITE = 48'hC000_C000_C000;
   localparam logic [47:0] BLUE  = 48'h8000_1000_1000;

   initial begin
      int base, c;
      @(posedge clock);
      chk_on = 1;
      repeat (4) @(negedge clock);
      check("rst_color", color, 0);
      check("rst_valid", color_valid, 0);
      check("rst_avg_red", avg_red, 0);
      check("rst_raw", raw_color, 0);
      value = RED;
      reset = 0;

      wait_win(1);
      check("red_raw", raw_color, 3);
      check("red_avg_r", avg_red, 8'h90);
      check("red_avg_g", avg_green, 8'h10);
      check("red_avg_b", avg_blue, 8'h20);
      wait_win(1);
      check("red_w2_color", color, 0);
      wait_win(1);
      check("red_color", color, 3);
      check("red_valid", color_valid, 1);
      check("red_changed", color_changed, 1);
      wait_win(2);
      check("red_one_pulse", dut_pulses, 1);

      for (int i = 0; i < 4; i++) begin
         value = {16'h0000, 16'h9000, bnd_g[i], 8'h00};
         wait_win(1);
         check("bnd_raw", raw_color, bnd_c[i]);
      end

      base = dut_pulses;
      for (int i = 0; i < 6; i++) begin
         value = (i % 2 == 1) ? BLUE : WHITE;
         wait_win(1);
      end
      @(negedge clock);
      check("flk_pulses", dut_pulses - base, 0);
      check("flk_color", color, 3);
      value = BLUE;
      wait_win(3);
      check("blue_color", color, 6);
      @(negedge clock);
      check("blue_pulses", dut_pulses - base, 1);

      for (int i = 0; i < 4; i++) begin
         value = {16'h0000, avg_r[i], 16'h0000};
         wait_samp();
      end
      wait_win(1);
      check("avg_edge_r", avg_red, 8'h10);
      check("avg_edge_raw", raw_color, 3);
      value = 48'h0;
      wait_win(2);
      check("dark_hold", color, 6);
      wait_win(1);
      check("dark_color", color, 0);
      check("dark_valid", color_valid, 1);
      check("dark_changed", color_changed, 1);

      value = RED;
      wait_win(1);
      c = 0;
      while (m_ns != 2 && c < 40) begin @(negedge clock); c++; end
      check("en_bound", m_ns, 2);
      enable = 0;
      repeat (4) @(negedge clock);
      check("en_avg_hold", avg_red, 8'h90);
      check("en_raw_hold", raw_color, 3);
      check("en_color_hold", color, 0);
      base = dut_pulses;
      enable = 1;
      wait_win(2);
      @(negedge clock);
      check("en_no_pulse", dut_pulses - base, 0);
      wait_win(1);
      check("en_color", color, 3);
      check("en_valid", color_valid, 1);

      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 5))
            4: repeat (30) begin
                  @(negedge clock);
                  value = {16'($urandom), 16'($urandom), 16'($urandom)};
               end
            5: begin
                  enable = 0;
                  repeat ($urandom_range(1, 5)) @(negedge clock);
                  enable = 1;
               end
            default: begin
                  value = tbl[$urandom_range(0, 5)];
                  wait_win($urandom_range(1, 4));
               end
         endcase
      end
      repeat (7) @(negedge clock);
      reset = 1;
      repeat (2) @(negedge clock);
      check("mid_rst_color", color, 0);
      reset = 0;
      value = BLUE;
      wait_win(3);
      check("post_rst_color", color, 6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/color_stabilizer.md
Name: color_stabilizer

Overview:
- Downstream consumer of the colour sensor's 48-bit raw reading word. Per-window order: sample, average, classify, debounce.
- Samples the word every SAMPLE_PERIOD clocks and averages 2^LOG_N samples per channel.
- Classifies the averages into one of the six cube colours, or none.
- Publishes a colour only after STABLE_COUNT consecutive identical window results.
- Gives the robot sequencer a clean colour plus a one-cycle strobe instead of a jittering per-poll guess.

Parameters:
- SAMPLE_PERIOD, 1000: clocks between raw captures (≥2).
- LOG_N, 2: log2 of samples per averaging window.
- STABLE_COUNT, 3: consecutive identical window classifications needed to publish (≥1).
- DARK_THRESH, 8'd16: if max channel average is below this, the result is NONE.
- WHITE_MIN, 8'd160: if min channel average is above this, the result is WHITE.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- enable  input  1  sensor configured and polling; low halts sampling
- value  input  48  raw reading {B[15:0], R[15:0], G[15:0]} (B at [47:32], R at [31:16], G at [15:0])
- avg_red  output  8  high byte of window-averaged R
- avg_green  output  8  high byte of window-averaged G
- avg_blue  output  8  high byte of window-averaged B
- raw_color  output  3  classification of last completed window
- color  output  3  debounced published colour
- color_valid  output  1  one-cycle pulse when color is (re)published
- color_changed  output  1  one-cycle pulse, coincident with color_valid, only when the published value differs from the previous one

Behaviour:
- Colour codes: 0 NONE, 1 WHITE, 2 YELLOW, 3 RED, 4 ORANGE, 5 GREEN, 6 BLUE; 7 is never produced.
- Reset: all outputs are 0; accumulators, sample count, period counter and stability counter are 0; state IDLE.
- States and transitions:
  - IDLE: wait for enable=1, then go to WAIT with the period counter at 0.
  - WAIT: the period counter increments. When it reaches SAMPLE_PERIOD-1, go to ACCUM.
  - ACCUM: one cycle.
    - Add each 16-bit channel of value into its own (16+LOG_N)-bit accumulator, zero-extended, with no overflow possible.
    - Increment the sample count.
    - If the count reaches 2^LOG_N, go to CLASSIFY. Otherwise go to WAIT with the counter at 0.
  - CLASSIFY: one cycle.
    - avg_* <= accumulator[15+LOG_N : 8+LOG_N], i.e. a truncating divide, high byte only.
    - raw_color <= f(avg values of this window).
    - Clear accumulators and count. Go to DEBOUNCE.
  - DEBOUNCE: one cycle.
    - If raw_color equals the previous window's class, the stability counter increments, saturating at STABLE_COUNT. Otherwise it loads 1.
    - When it first reaches STABLE_COUNT: color <= raw_color and color_valid=1. color_changed=1 if the new color differs from the old one.
    - While saturated and unchanged, no further pulses.
    - Then go to WAIT with the counter at 0.
- Classification f(r,g,b), first match wins:
  1. max(r,g,b) < DARK_THRESH → NONE.
  2. min > WHITE_MIN → WHITE.
  3. Dominant channel by max, ties resolved R > G > B. B dominant → BLUE; G dominant → GREEN.
  4. R dominant: 4g ≥ 3r → YELLOW; else 4g ≥ r → ORANGE; else RED. Use 10-bit products.
- Latency: avg_* and raw_color update 1 clock after the final ACCUM. color and color_valid follow 1 clock later.
- enable falling in any state:
  - Next cycle: state IDLE; accumulators, count and stability counter clear.
  - color, avg_* and raw_color hold.
  - A partial window is discarded.
- reset mid-window overrides everything and clears all outputs to 0.
- First window after reset or enable: the previous class is treated as invalid, so the stability counter loads 1.
- value is sampled only in ACCUM; changes at any other time are ignored.

Optional Feature:
- Macro COLOR_STAB_STATS_EN.
- Defined: adds output change_count [15:0].
  - Reset 0.
  - Increments on each color_changed pulse and saturates at 16'hFFFF.
  - Not cleared by enable low.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset values: reset high 5 clocks with enable=1 → all outputs 0, no pulses. value is never captured while reset is high.
- Red publish:
  - Setup: SAMPLE_PERIOD=4, LOG_N=2, STABLE_COUNT=3, value=48'h2000_9000_1000 constant.
  - Averages: avg_red=0x90, avg_green=0x10, avg_blue=0x20.
  - Windows: raw_color=3 after window 1. Windows 1–2 give no pulse.
  - Window 3: color=3 with color_valid and color_changed high for 1 clock. No further pulses afterwards.
- Red/yellow/orange boundary, R=0x90: G=0x6C (4g=432=3r) → YELLOW. G=0x6B → ORANGE. G=0x24 (4g=144=r) → ORANGE. G=0x23 → RED.
- Flicker rejection:
  - Alternate windows WHITE (all 0xC000) and BLUE (B=0x8000, others 0x1000).
  - color never changes from prior value and color_valid never pulses.
  - Then 3 BLUE windows → color=6 with one pulse.
- Averaging and dark:
  - Samples R=0x0F00,0x0F00,0x1100,0x1100 → avg_red=0x10 = DARK_THRESH → not NONE.
  - All-zero input → NONE after 3 windows. color_changed=1 only if previous color≠0.
- enable drop: enable low after 2 samples of a window → averages hold, stability counter cleared. On re-enable, full 3 windows are required before the next color_valid.
